arith_op_sequencer: RTL
=======================

Name: arith_op_sequencer

Overview:
- Valid/ready front-end and result-capture stage for the 4-bit combinational add/subtract unit.
- Accepts one operation request (A, B, Sel), drives the unit's operand inputs from registers, and waits a fixed settle time.
- Captures Result/CarryOut into an output register, then holds it under downstream backpressure.
- Sits between the switch/command source and the display or result consumer.

Parameters:
- WIDTH, 4, operand/result width; must equal the arithmetic unit width.
- SETTLE_CYCLES, 1, cycles between driving operands and capturing the result; legal range 1..15.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  request valid.
- InReady  out  1  request accepted when InValid && InReady at a rising edge.
- InA  in  WIDTH  operand A.
- InB  in  WIDTH  operand B.
- InSel  in  1  0 = add, 1 = subtract.
- AluA  out  WIDTH  registered operand A to the arithmetic unit.
- AluB  out  WIDTH  registered operand B to the arithmetic unit.
- AluSel  out  1  registered Sel to the arithmetic unit.
- AluResult  in  WIDTH  Result from the arithmetic unit.
- AluCarry  in  1  CarryOut (add) or Borrow (sub) from the arithmetic unit.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer ready.
- OutResult  out  WIDTH  captured result.
- OutCarry  out  1  captured carry/borrow.
- OutSel  out  1  Sel of the captured operation.
- OutOverflow  out  1  signed overflow flag (see Optional Feature).
- OpCount  out  CNT_W  count of completed output handshakes.
- Busy  out  1  high in DRIVE or HOLD.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0 except InReady = 1. Applies in every state; an in-flight operation is discarded and no output handshake is produced.
- States: IDLE, DRIVE, HOLD.
- IDLE:
  - InReady = 1, OutValid = 0.
  - On accept: AluA/AluB/AluSel <= InA/InB/InSel, settle counter <= SETTLE_CYCLES-1, go to DRIVE.
- DRIVE:
  - InReady = 0.
  - Counter decrements each cycle. When it is 0: capture AluResult/AluCarry/AluSel (and overflow) into the Out* registers, set OutValid, go to HOLD.
  - Latency: accept at edge k gives OutValid high after edge k+SETTLE_CYCLES.
- HOLD:
  - OutValid = 1. OutResult/OutCarry/OutSel/OutOverflow stay stable while OutReady = 0.
  - InReady = OutReady (combinational).
  - OutReady && !InValid: OutValid <= 0, go to IDLE.
  - OutReady && InValid: retire the current result and accept the new request in the same edge, go to DRIVE. Back-to-back throughput is one op per SETTLE_CYCLES+1 cycles.
- AluA/AluB/AluSel keep the last operands after completion; they change only on accept or reset.
- OpCount increments on each OutValid && OutReady edge and wraps from 2^CNT_W-1 to 0.
- Inputs are not sampled outside accept edges. InA/InB/InSel may change freely when InReady is 0.
- Arithmetic is unsigned modulo 2^WIDTH. For Sel = 1, OutCarry = 1 means borrow (A < B).

Optional Feature:
- Macro: ARITH_OVERFLOW_FLAG_EN.
- Defined: OutOverflow is captured alongside OutResult (m = WIDTH-1).
  - Add: (AluA[m] == AluB[m]) && (AluResult[m] != AluA[m]).
  - Sub: (AluA[m] != AluB[m]) && (AluResult[m] != AluA[m]).
- Not defined: OutOverflow is tied to 0. The port remains so the interface is identical in both builds.

Decomposition:
- Package arith_pkg holds:
  - ARITH_WIDTH = 4.
  - SEL_ADD = 1'b0, SEL_SUB = 1'b1.
  - Sequencer state encoding: IDLE = 2'd0, DRIVE = 2'd1, HOLD = 2'd2.
- One natural sub-module: arith_overflow_detect, combinational, compiled only under ARITH_OVERFLOW_FLAG_EN. Everything else stays in arith_op_sequencer.
- The bench instantiates ArithmeticUnit and connects it through the Alu* ports.

Test Plan:
- Basic add/sub: 3+2 with OutReady = 1 -> OutValid one cycle after DRIVE (SETTLE_CYCLES = 1), OutResult = 5, OutCarry = 0. Then 3-2 -> 1, OutCarry = 0, OpCount = 2.
- Overflow/carry cases (macro on):
  - 7+5 -> 12, carry 0, overflow 1.
  - 8+9 -> 1, carry 1, overflow 1.
  - 5-6 -> 15, borrow 1, overflow 0.
  - 10-8 -> 2, borrow 0, overflow 0.
  - Macro off: OutOverflow = 0 in all of these.
- Backpressure: hold OutReady = 0 for 5 cycles after 7+5 and change InA/InB meanwhile -> OutResult stays 12, InReady stays 0, OpCount unchanged. Release -> one handshake, OpCount +1.
- Back-to-back: InValid held with ops 1+1, 2+2, 3+3 and OutReady = 1, SETTLE_CYCLES = 3 -> results 2, 4, 6 in order, spaced 4 cycles apart, each accept coincides with the previous retire.
- Reset mid-operation: assert rst_n low during DRIVE -> immediately OutValid = 0, InReady = 1, Alu* = 0, OpCount = 0. No stale result appears after reset release.
- Counter wrap: 256 completed ops with CNT_W = 8 -> OpCount returns to 0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared constants and state encoding for the add/subtract sequencer.
package arith_pkg;

    localparam int unsigned ARITH_WIDTH = 4;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } seq_state_e;

endpackage : arith_pkg

// File: rtl/ArithmeticUnit.sv
// 4-bit combinational add/subtract unit; CarryOut is carry on add, borrow on subtract.
module ArithmeticUnit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sel,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut
);

    logic [WIDTH:0] ext_c;

    // Extended-width add or subtract; the top bit is carry or borrow.
    always_comb begin
        if (Sel) begin
            ext_c = {1'b0, A} - {1'b0, B};
        end else begin
            ext_c = {1'b0, A} + {1'b0, B};
        end
        Result   = ext_c[WIDTH-1:0];
        CarryOut = ext_c[WIDTH];
    end

endmodule : ArithmeticUnit

// File: rtl/arith_overflow_detect.sv
// Signed two's-complement overflow for add/subtract.
// Present only when ARITH_OVERFLOW_FLAG_EN is defined.
`ifdef ARITH_OVERFLOW_FLAG_EN
module arith_overflow_detect
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int unsigned M = WIDTH - 1;

    // Sign of result differs from A when operand signs make overflow possible.
    always_comb begin
        overflow = 1'b0;
        if (sel == SEL_SUB) begin
            overflow = (a[M] != b[M]) && (result[M] != a[M]);
        end else begin
            overflow = (a[M] == b[M]) && (result[M] != a[M]);
        end
    end

endmodule : arith_overflow_detect
`endif

// File: rtl/arith_op_sequencer.sv
// Valid/ready front-end and result capture for the add/subtract unit.
// Optional signed-overflow flag: define ARITH_OVERFLOW_FLAG_EN.
module arith_op_sequencer
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH         = ARITH_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic             InSel,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic             AluSel,
    input  logic [WIDTH-1:0] AluResult,
    input  logic             AluCarry,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutResult,
    output logic             OutCarry,
    output logic             OutSel,
    output logic             OutOverflow,
    output logic [CNT_W-1:0] OpCount,
    output logic             Busy
);

    localparam int unsigned         SETTLE_W    = 4;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    seq_state_e          state;
    seq_state_e          state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                accept_c;
    logic                capture_c;
    logic                retire_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (InValid) state_nxt = DRIVE;
            DRIVE:   if (settle_cnt == '0) state_nxt = HOLD;
            HOLD:    if (OutReady) state_nxt = InValid ? DRIVE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and control decode; in HOLD a new request rides on the retire edge.
    always_comb begin
        InReady   = 1'b0;
        Busy      = 1'b0;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        retire_c  = 1'b0;
        case (state)
            IDLE: begin
                InReady  = 1'b1;
                accept_c = InValid;
            end
            DRIVE: begin
                Busy      = 1'b1;
                capture_c = (settle_cnt == '0);
            end
            HOLD: begin
                Busy     = 1'b1;
                InReady  = OutReady;
                retire_c = OutReady;
                accept_c = OutReady && InValid;
            end
            default: ;
        endcase
    end

    // Operand registers and settle counter; operands move only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AluA       <= '0;
            AluB       <= '0;
            AluSel     <= 1'b0;
            settle_cnt <= '0;
        end else if (accept_c) begin
            AluA       <= InA;
            AluB       <= InB;
            AluSel     <= InSel;
            settle_cnt <= SETTLE_LOAD;
        end else if (state == DRIVE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
        end
    end

    // Result capture; held stable until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OutValid  <= 1'b0;
            OutResult <= '0;
            OutCarry  <= 1'b0;
            OutSel    <= 1'b0;
        end else if (capture_c) begin
            OutValid  <= 1'b1;
            OutResult <= AluResult;
            OutCarry  <= AluCarry;
            OutSel    <= AluSel;
        end else if (retire_c) begin
            OutValid  <= 1'b0;
        end
    end

    // Completed-handshake counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OpCount <= '0;
        end else if (retire_c) begin
            OpCount <= OpCount + CNT_W'(1);
        end
    end

`ifdef ARITH_OVERFLOW_FLAG_EN
    logic ovf_c;
    logic out_ovf_q;

    arith_overflow_detect #(
        .WIDTH(WIDTH)
    ) u_ovf (
        .a       (AluA),
        .b       (AluB),
        .sel     (AluSel),
        .result  (AluResult),
        .overflow(ovf_c)
    );

    // Overflow flag captured alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf_q <= 1'b0;
        end else if (capture_c) begin
            out_ovf_q <= ovf_c;
        end
    end

    assign OutOverflow = out_ovf_q;
`else
    assign OutOverflow = 1'b0;
`endif

endmodule : arith_op_sequencer
